// File: rtl/vector_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : vector_exec_unit
// Purpose  : Element-wise vector engine. Streams a vector tile by tile from
//            the buffer file and applies RELU, ADD_SAT, REQUANT or ADD_RELU
//            to every lane in parallel. Each result tile is written back to a
//            destination buffer with a per-lane mask for a partial last tile.
//            The write port honours backpressure.
// Ports    : clk, reset_n          clock / async active-low reset
//            start, mode, src_a_id, src_b_id, dest_id, length, scale, shift
//                                  command, latched on start in IDLE
//            rd_en, rd_buf, rd_tile_idx, rd_data
//                                  tile read port; data arrives 1 cycle later
//            wr_en, wr_ready, wr_buf, wr_tile_idx, wr_data, wr_mask
//                                  tile write port with ready handshake
//            busy, done, error     status (done = 1-cycle pulse, error sticky)
// Revision : 1.0 - initial release
// ============================================================================
module vector_exec_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_ELEMS = 32,
    parameter int MAX_LEN    = 784,
    parameter int BUF_ID_W   = 5,
    parameter int LEN_W      = 10,
    parameter int SHIFT_W    = 4,
    // Derived from the parameters above; not meant to be overridden.
    parameter int MAX_TILES  = (MAX_LEN + TILE_ELEMS - 1) / TILE_ELEMS,
    parameter int IDX_W      = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [1:0]                       mode,
    input  logic [BUF_ID_W-1:0]              src_a_id,
    input  logic [BUF_ID_W-1:0]              src_b_id,
    input  logic [BUF_ID_W-1:0]              dest_id,
    input  logic [LEN_W-1:0]                 length,
    input  logic [DATA_WIDTH-1:0]            scale,
    input  logic [SHIFT_W-1:0]               shift,
    output logic                             rd_en,
    output logic [BUF_ID_W-1:0]              rd_buf,
    output logic [IDX_W-1:0]                 rd_tile_idx,
    input  logic [TILE_ELEMS*DATA_WIDTH-1:0] rd_data,
    output logic                             wr_en,
    input  logic                             wr_ready,
    output logic [BUF_ID_W-1:0]              wr_buf,
    output logic [IDX_W-1:0]                 wr_tile_idx,
    output logic [TILE_ELEMS*DATA_WIDTH-1:0] wr_data,
    output logic [TILE_ELEMS-1:0]            wr_mask,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int c_TW = TILE_ELEMS * DATA_WIDTH;
    localparam int c_PW = 2 * DATA_WIDTH + 1;

    localparam logic [1:0] c_MODE_RELU    = 2'd0;
    localparam logic [1:0] c_MODE_ADD_SAT = 2'd1;
    localparam logic [1:0] c_MODE_REQUANT = 2'd2;

    localparam logic signed [c_PW-1:0] c_SAT_MAX = c_PW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [c_PW-1:0] c_SAT_MIN = -c_SAT_MAX - c_PW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_A   = 3'd1,
        S_CAP_A  = 3'd2,
        S_CAP_B  = 3'd3,
        S_WRITE  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t                      r_state;
    logic [1:0]                  r_mode;
    logic [BUF_ID_W-1:0]         r_src_a;
    logic [BUF_ID_W-1:0]         r_src_b;
    logic [BUF_ID_W-1:0]         r_dest;
    logic [LEN_W-1:0]            r_len;
    logic signed [DATA_WIDTH-1:0] r_scale;
    logic [SHIFT_W-1:0]          r_shift;
    logic [IDX_W-1:0]            r_tile;
    logic [IDX_W-1:0]            r_last;
    logic [c_TW-1:0]             r_a;
    logic [c_TW-1:0]             r_b;
    logic                        r_rd_en;
    logic [BUF_ID_W-1:0]         r_rd_buf;
    logic                        r_wr_en;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_error;

    logic                        w_len_bad;
    logic                        w_is_add;
    logic [TILE_ELEMS-1:0]       w_mask;
    logic [c_TW-1:0]             w_y;

    // Clamp a wide signed intermediate into the element range.
    function automatic logic [DATA_WIDTH-1:0] f_sat(input logic signed [c_PW-1:0] v);
        if (v > c_SAT_MAX) begin
            return c_SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < c_SAT_MIN) begin
            return c_SAT_MIN[DATA_WIDTH-1:0];
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    // One lane of the datapath; every lane is an identical copy.
    function automatic logic [DATA_WIDTH-1:0] f_lane(
        input logic [1:0]                   m,
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b,
        input logic signed [DATA_WIDTH-1:0] sc,
        input logic [SHIFT_W-1:0]           sh
    );
        logic signed [DATA_WIDTH:0]     sum;
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [c_PW-1:0]         wide;
        logic signed [c_PW-1:0]         rnd;
        logic signed [c_PW-1:0]         p;
        logic [DATA_WIDTH-1:0]          y;

        // DW+1 bits cannot overflow for a sum of two DW-bit values.
        sum  = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        wide = {{DATA_WIDTH{sum[DATA_WIDTH]}}, sum};

        // Adding half an LSB of the shifted result before the arithmetic
        // shift gives round-half-up (towards +inf on ties).
        prod = a * sc;
        rnd  = (sh != '0) ? (c_PW'(1) << (sh - 1'b1)) : '0;
        p    = {prod[2*DATA_WIDTH-1], prod} + rnd;
        p    = p >>> sh;

        case (m)
            c_MODE_RELU:    y = a[DATA_WIDTH-1] ? '0 : a;
            c_MODE_ADD_SAT: y = f_sat(wide);
            c_MODE_REQUANT: y = f_sat(p);
            default:        y = wide[c_PW-1] ? '0 : f_sat(wide);
        endcase
        return y;
    endfunction

    assign w_len_bad = (length == '0) || (32'(length) > 32'(MAX_LEN));
    // Modes 1 and 3 are the two-operand modes.
    assign w_is_add  = r_mode[0];

    for (genvar gi = 0; gi < TILE_ELEMS; gi++) begin : g_lane
        assign w_mask[gi] = (32'(r_tile) * 32'(TILE_ELEMS) + 32'(gi)) < 32'(r_len);
        assign w_y[gi*DATA_WIDTH +: DATA_WIDTH] =
            w_mask[gi] ? f_lane(r_mode,
                                r_a[gi*DATA_WIDTH +: DATA_WIDTH],
                                r_b[gi*DATA_WIDTH +: DATA_WIDTH],
                                r_scale, r_shift)
                       : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mode   <= '0;
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_dest   <= '0;
            r_len    <= '0;
            r_scale  <= '0;
            r_shift  <= '0;
            r_tile   <= '0;
            r_last   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd_en  <= 1'b0;
            r_rd_buf <= '0;
            r_wr_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_src_a <= src_a_id;
                        r_src_b <= src_b_id;
                        r_dest  <= dest_id;
                        r_len   <= length;
                        r_scale <= scale;
                        r_shift <= shift;
                        r_tile  <= '0;
                        r_last  <= IDX_W'((32'(length) - 32'd1) / 32'(TILE_ELEMS));
                        r_busy  <= 1'b1;
                        if (w_len_bad) begin
                            r_error <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_error  <= 1'b0;
                            r_rd_en  <= 1'b1;
                            r_rd_buf <= src_a_id;
                            r_state  <= S_RD_A;
                        end
                    end
                end

                S_RD_A: begin
                    // Operand B is requested while A's data is on the bus.
                    r_state <= S_CAP_A;
                    if (w_is_add) begin
                        r_rd_en  <= 1'b1;
                        r_rd_buf <= r_src_b;
                    end else begin
                        r_rd_en  <= 1'b0;
                        r_rd_buf <= '0;
                    end
                end

                S_CAP_A: begin
                    r_a      <= rd_data;
                    r_rd_en  <= 1'b0;
                    r_rd_buf <= '0;
                    if (w_is_add) begin
                        r_state <= S_CAP_B;
                    end else begin
                        r_wr_en <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end

                S_CAP_B: begin
                    r_b     <= rd_data;
                    r_wr_en <= 1'b1;
                    r_state <= S_WRITE;
                end

                S_WRITE: begin
                    if (wr_ready) begin
                        r_wr_en <= 1'b0;
                        if (r_tile == r_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_tile   <= r_tile + 1'b1;
                            r_rd_en  <= 1'b1;
                            r_rd_buf <= r_src_a;
                            r_state  <= S_RD_A;
                        end
                    end
                end

                S_FINISH: begin
                    // A rejected command enters with done low and spends one
                    // extra cycle here before its pulse; a completed command
                    // enters with done already high.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end

                default: begin
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en       = r_rd_en;
    assign rd_buf      = r_rd_buf;
    assign rd_tile_idx = r_tile;
    assign wr_en       = r_wr_en;
    assign wr_buf      = r_dest;
    assign wr_tile_idx = r_tile;
    // Result is formed from the operand registers, so it is stable for the
    // whole WRITE state regardless of how long wr_ready is withheld.
    assign wr_data     = (r_state == S_WRITE) ? w_y    : '0;
    assign wr_mask     = (r_state == S_WRITE) ? w_mask : '0;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_vector_exec_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vector_exec_unit
// Purpose  : Directed self-checking bench for vector_exec_unit. A behavioural
//            buffer file answers reads one cycle after rd_en, and a monitor
//            logs reads, write handshakes and done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_exec_unit;

    localparam int DW      = 8;
    localparam int TE      = 32;
    localparam int MAX_LEN = 784;
    localparam int BW      = 5;
    localparam int LW      = 10;
    localparam int SW      = 4;
    localparam int IW      = 5;
    localparam int TW      = TE * DW;

    localparam logic [BW-1:0] ID_A = 5'd1;
    localparam logic [BW-1:0] ID_B = 5'd2;
    localparam logic [BW-1:0] ID_D = 5'd9;

    logic            clk      = 1'b0;
    logic            reset_n  = 1'b0;
    logic            start    = 1'b0;
    logic [1:0]      mode     = 2'd0;
    logic [BW-1:0]   src_a_id = ID_A;
    logic [BW-1:0]   src_b_id = ID_B;
    logic [BW-1:0]   dest_id  = ID_D;
    logic [LW-1:0]   length   = '0;
    logic [DW-1:0]   scale    = '0;
    logic [SW-1:0]   shift    = '0;
    logic            rd_en;
    logic [BW-1:0]   rd_buf;
    logic [IW-1:0]   rd_tile_idx;
    logic [TW-1:0]   rd_data  = '0;
    logic            wr_en;
    logic            wr_ready = 1'b1;
    logic [BW-1:0]   wr_buf;
    logic [IW-1:0]   wr_tile_idx;
    logic [TW-1:0]   wr_data;
    logic [TE-1:0]   wr_mask;
    logic            busy;
    logic            done;
    logic            error;

    vector_exec_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_a_id(src_a_id), .src_b_id(src_b_id), .dest_id(dest_id),
        .length(length), .scale(scale), .shift(shift),
        .rd_en(rd_en), .rd_buf(rd_buf), .rd_tile_idx(rd_tile_idx), .rd_data(rd_data),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_buf(wr_buf), .wr_tile_idx(wr_tile_idx),
        .wr_data(wr_data), .wr_mask(wr_mask), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] memA [0:1023];
    logic [DW-1:0] memB [0:1023];

    // Buffer file: answers with the addressed tile one cycle after rd_en;
    // the bus carries filler otherwise so a mistimed capture is visible.
    always @(posedge clk) begin : p_rd
        logic          v_en;
        logic [BW-1:0] v_buf;
        logic [IW-1:0] v_idx;
        int            k;
        v_en  = rd_en;
        v_buf = rd_buf;
        v_idx = rd_tile_idx;
        #1;
        for (int i = 0; i < TE; i++) begin
            k = int'(v_idx) * TE + i;
            if (!v_en)             rd_data[i*DW +: DW] = 8'hA5;
            else if (v_buf == ID_A) rd_data[i*DW +: DW] = memA[k];
            else if (v_buf == ID_B) rd_data[i*DW +: DW] = memB[k];
            else                    rd_data[i*DW +: DW] = 8'h00;
        end
    end

    int            n_rd;
    int            n_done;
    logic [BW-1:0] q_rdbuf [$];
    logic [IW-1:0] q_idx   [$];
    logic [TW-1:0] q_data  [$];
    logic [TE-1:0] q_mask  [$];
    logic [BW-1:0] q_wbuf  [$];

    always @(posedge clk) begin : p_mon
        if (rd_en) begin
            n_rd++;
            q_rdbuf.push_back(rd_buf);
        end
        if (wr_en && wr_ready) begin
            q_idx.push_back(wr_tile_idx);
            q_data.push_back(wr_data);
            q_mask.push_back(wr_mask);
            q_wbuf.push_back(wr_buf);
        end
        if (done) n_done++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_rd   = 0;
        n_done = 0;
        q_rdbuf.delete();
        q_idx.delete();
        q_data.delete();
        q_mask.delete();
        q_wbuf.delete();
    endtask

    // Issues one command and returns the cycle (counted from the start
    // cycle) in which done is seen. Optionally withholds wr_ready for the
    // first stall_n WRITE cycles, and optionally fires a conflicting start
    // while the unit is busy.
    task automatic run_cmd(input logic [1:0] m, input int len, input int stall_n,
                           input bit poke, output int lat);
        int            stall_left;
        bit            snapped;
        logic [TW-1:0] s_data;
        logic [TE-1:0] s_mask;
        logic [IW-1:0] s_idx;
        mode   = m;
        length = LW'(len);
        clear_log();
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 1;
        stall_left = stall_n;
        snapped    = 1'b0;
        while (!done && lat < 300) begin
            if (poke && lat == 2) begin
                start   = 1'b1;
                mode    = 2'd2;
                length  = LW'(1);
                dest_id = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (wr_en && stall_left > 0) begin
                wr_ready = 1'b0;
                if (!snapped) begin
                    s_data  = wr_data;
                    s_mask  = wr_mask;
                    s_idx   = wr_tile_idx;
                    snapped = 1'b1;
                end else begin
                    check_val("stall_wr_en",   TW'(wr_en), TW'(1));
                    check_val("stall_wr_data", wr_data, s_data);
                    check_val("stall_wr_mask", TW'(wr_mask), TW'(s_mask));
                    check_val("stall_wr_idx",  TW'(wr_tile_idx), TW'(s_idx));
                end
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
            tick();
            lat++;
        end
        start    = 1'b0;
        wr_ready = 1'b1;
        mode     = m;
        dest_id  = ID_D;
        check_val("done_seen", TW'(done), TW'(1));
    endtask

    task automatic init_relu_pattern();
        for (int k = 0; k < 1024; k++) begin
            memA[k] = (k % 2 == 0) ? 8'hFB : 8'h07;   // -5 / 7
            memB[k] = 8'h00;
        end
    endtask

    // Expected RELU result of the alternating -5/7 pattern: odd elements
    // below len become 7, everything else 0.
    function automatic logic [TW-1:0] relu_pat_tile(input int t, input int len);
        logic [TW-1:0] v;
        int            k;
        v = '0;
        for (int i = 0; i < TE; i++) begin
            k = t * TE + i;
            if (k < len && (k % 2) == 1) v[i*DW +: DW] = 8'd7;
        end
        return v;
    endfunction

    function automatic logic [TW-1:0] lanes4(input logic [7:0] l0, input logic [7:0] l1,
                                             input logic [7:0] l2, input logic [7:0] l3);
        logic [TW-1:0] v;
        v = '0;
        v[31:0] = {l3, l2, l1, l0};
        return v;
    endfunction

    initial begin : p_main
        int            lat;
        int            n;
        logic [TW-1:0] exp_t;

        init_relu_pattern();
        clear_log();
        tick();
        tick();
        check_val("rst_busy",  TW'(busy),    TW'(0));
        check_val("rst_done",  TW'(done),    TW'(0));
        check_val("rst_error", TW'(error),   TW'(0));
        check_val("rst_rd_en", TW'(rd_en),   TW'(0));
        check_val("rst_wr_en", TW'(wr_en),   TW'(0));
        check_val("rst_mask",  TW'(wr_mask), TW'(0));
        reset_n = 1'b1;
        tick();

        // RELU over two tiles, the second one partial.
        run_cmd(2'd0, 40, 0, 1'b0, lat);
        check_val("relu_lat", TW'(lat), TW'(7));
        tick(); tick();
        check_val("relu_nwr",   TW'(q_data.size()), TW'(2));
        check_val("relu_nrd",   TW'(n_rd), TW'(2));
        check_val("relu_idx0",  TW'(q_idx[0]), TW'(0));
        check_val("relu_idx1",  TW'(q_idx[1]), TW'(1));
        check_val("relu_d0",    q_data[0], relu_pat_tile(0, 40));
        check_val("relu_d1",    q_data[1], relu_pat_tile(1, 40));
        check_val("relu_m0",    TW'(q_mask[0]), TW'(32'hFFFF_FFFF));
        check_val("relu_m1",    TW'(q_mask[1]), TW'(32'h0000_00FF));
        check_val("relu_wbuf",  TW'(q_wbuf[1]), TW'(ID_D));
        check_val("relu_ndone", TW'(n_done), TW'(1));
        check_val("relu_busy",  TW'(busy), TW'(0));

        // ADD_SAT, one full tile, includes both saturation directions.
        memA[0] = 8'd100; memB[0] = 8'd100;
        memA[1] = 8'h9C;  memB[1] = 8'hCE;   // -100, -50
        memA[2] = 8'd3;   memB[2] = 8'hFC;   // 3, -4
        for (int i = 3; i < TE; i++) begin
            memA[i] = 8'(i);
            memB[i] = 8'd1;
        end
        exp_t = '0;
        exp_t[7:0] = 8'h7F; exp_t[15:8] = 8'h80; exp_t[23:16] = 8'hFF;
        for (int i = 3; i < TE; i++) exp_t[i*DW +: DW] = 8'(i + 1);
        run_cmd(2'd1, 32, 0, 1'b0, lat);
        check_val("add_lat", TW'(lat), TW'(5));
        tick(); tick();
        check_val("add_nrd",   TW'(n_rd), TW'(2));
        check_val("add_rdbuf0", TW'(q_rdbuf[0]), TW'(ID_A));
        check_val("add_rdbuf1", TW'(q_rdbuf[1]), TW'(ID_B));
        check_val("add_data",  q_data[0], exp_t);
        check_val("add_mask",  TW'(q_mask[0]), TW'(32'hFFFF_FFFF));

        // ADD_RELU: saturate then clamp negatives.
        memA[0] = 8'd100; memB[0] = 8'd100;
        memA[1] = 8'hFD;  memB[1] = 8'd1;    // -3 + 1
        memA[2] = 8'd5;   memB[2] = 8'hFE;   // 5 - 2
        run_cmd(2'd3, 3, 0, 1'b0, lat);
        tick();
        check_val("arelu_data", q_data[0], lanes4(8'h7F, 8'h00, 8'h03, 8'h00));
        check_val("arelu_mask", TW'(q_mask[0]), TW'(32'h7));

        // REQUANT with rounding, then both saturation limits.
        memA[0] = 8'd5; memA[1] = 8'hFB; memA[2] = 8'd0; memA[3] = 8'd8;
        scale = 8'd3; shift = 4'd2;
        run_cmd(2'd2, 4, 0, 1'b0, lat);
        check_val("rq_lat", TW'(lat), TW'(4));
        tick();
        check_val("rq_data", q_data[0], lanes4(8'h04, 8'hFC, 8'h00, 8'h06));
        check_val("rq_mask", TW'(q_mask[0]), TW'(32'hF));
        memA[0] = 8'd127; memA[1] = 8'hFF;
        scale = 8'd127; shift = 4'd0;
        run_cmd(2'd2, 2, 0, 1'b0, lat);
        tick();
        check_val("rq_satpos", q_data[0], lanes4(8'h7F, 8'h81, 8'h00, 8'h00));
        scale = 8'h80;
        run_cmd(2'd2, 2, 0, 1'b0, lat);
        tick();
        check_val("rq_satneg", q_data[0], lanes4(8'h80, 8'h7F, 8'h00, 8'h00));
        scale = 8'd0;

        // Backpressure: unstalled reference then 5 stalled cycles in tile 0.
        init_relu_pattern();
        run_cmd(2'd0, 64, 0, 1'b0, lat);
        check_val("bp_ref_lat", TW'(lat), TW'(7));
        tick();
        run_cmd(2'd0, 64, 5, 1'b0, lat);
        check_val("bp_lat", TW'(lat), TW'(12));
        tick();
        check_val("bp_nwr", TW'(q_data.size()), TW'(2));
        check_val("bp_d0",  q_data[0], relu_pat_tile(0, 64));
        check_val("bp_d1",  q_data[1], relu_pat_tile(1, 64));

        // Start while busy must be ignored.
        run_cmd(2'd0, 64, 0, 1'b1, lat);
        check_val("poke_lat", TW'(lat), TW'(7));
        for (int i = 0; i < 5; i++) tick();
        check_val("poke_nwr",   TW'(q_data.size()), TW'(2));
        check_val("poke_wbuf",  TW'(q_wbuf[0]), TW'(ID_D));
        check_val("poke_m1",    TW'(q_mask[1]), TW'(32'hFFFF_FFFF));
        check_val("poke_d1",    q_data[1], relu_pat_tile(1, 64));
        check_val("poke_ndone", TW'(n_done), TW'(1));

        // Bad commands.
        run_cmd(2'd0, 0, 0, 1'b0, lat);
        check_val("bad0_lat", TW'(lat), TW'(2));
        check_val("bad0_err", TW'(error), TW'(1));
        tick(); tick();
        check_val("bad0_nrd",  TW'(n_rd), TW'(0));
        check_val("bad0_nwr",  TW'(q_data.size()), TW'(0));
        check_val("bad0_hold", TW'(error), TW'(1));
        run_cmd(2'd0, 785, 0, 1'b0, lat);
        check_val("bad785_lat", TW'(lat), TW'(2));
        check_val("bad785_err", TW'(error), TW'(1));
        tick(); tick();
        check_val("bad785_nrd", TW'(n_rd), TW'(0));
        run_cmd(2'd0, 784, 0, 1'b0, lat);
        check_val("max_lat", TW'(lat), TW'(3 * 25 + 1));
        check_val("max_err", TW'(error), TW'(0));
        tick();
        check_val("max_nwr",  TW'(q_data.size()), TW'(25));
        check_val("max_m24",  TW'(q_mask[24]), TW'(32'h0000_FFFF));
        check_val("max_idx24", TW'(q_idx[24]), TW'(24));

        // Reset in WRITE of tile 1.
        mode   = 2'd0;
        length = LW'(40);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n = 0;
        while (!(wr_en && wr_tile_idx == 5'd1) && n < 50) begin
            tick();
            n++;
        end
        check_val("rstmid_found", TW'(wr_en && wr_tile_idx == 5'd1), TW'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rstmid_wr_en", TW'(wr_en), TW'(0));
        check_val("rstmid_busy",  TW'(busy),  TW'(0));
        tick();
        reset_n = 1'b1;
        tick();
        check_val("rstrel_busy",  TW'(busy),  TW'(0));
        check_val("rstrel_rd_en", TW'(rd_en), TW'(0));
        check_val("rstrel_done",  TW'(done),  TW'(0));
        run_cmd(2'd0, 40, 0, 1'b0, lat);
        check_val("post_lat", TW'(lat), TW'(7));
        tick();
        check_val("post_d0", q_data[0], relu_pat_tile(0, 40));
        check_val("post_d1", q_data[1], relu_pat_tile(1, 40));
        check_val("post_m1", TW'(q_mask[1]), TW'(32'h0000_00FF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_exec_unit.md
Name: vector_exec_unit

Overview:
Parametrised element-wise vector execution engine, the successor to the single-tile ReLU path of the execution unit.
It streams an arbitrary-length vector tile by tile from the vector buffer file, applies one of four modes (RELU, ADD_SAT, REQUANT, ADD_RELU), and writes the result tiles back to a destination buffer.
Partial last tiles are masked, and the write port supports backpressure.
It sits beside top_gemv under the execution FSM, which drives start/done.

Parameters:
DATA_WIDTH, 8, signed element width
TILE_ELEMS, 32, elements per tile
MAX_LEN, 784, maximum vector length in elements
BUF_ID_W, 5, buffer id width
LEN_W, 10, length field width
SHIFT_W, 4, requant shift width
Derived: MAX_TILES = ceil(MAX_LEN/TILE_ELEMS); IDX_W = max(1, $clog2(MAX_TILES))

Ports:
clk  in  1  clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
start  in  1  command strobe, accepted only in IDLE
mode  in  2  0 RELU, 1 ADD_SAT, 2 REQUANT, 3 ADD_RELU
src_a_id  in  BUF_ID_W  operand A buffer
src_b_id  in  BUF_ID_W  operand B buffer (modes 1/3)
dest_id  in  BUF_ID_W  result buffer
length  in  LEN_W  element count
scale  in  DATA_WIDTH  signed requant multiplier
shift  in  SHIFT_W  requant right shift
rd_en  out  1  buffer read request
rd_buf  out  BUF_ID_W  read buffer id
rd_tile_idx  out  IDX_W  read tile index
rd_data  in  TILE_ELEMS*DATA_WIDTH  packed tile, valid exactly 1 cycle after rd_en
wr_en  out  1  write request
wr_ready  in  1  write accepted when wr_en && wr_ready
wr_buf  out  BUF_ID_W  always equals latched dest_id
wr_tile_idx  out  IDX_W  write tile index
wr_data  out  TILE_ELEMS*DATA_WIDTH  packed result; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_mask  out  TILE_ELEMS  per-lane valid
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse
error  out  1  sticky flag for a bad command

Behaviour:
- Reset (reset_n=0): state IDLE; all outputs 0, including error; internal index and registers 0. Takes effect immediately, including mid-operation; any pending write is abandoned.
- Command acceptance: start in IDLE latches mode, ids, length, scale and shift, and clears error. start outside IDLE is ignored.
- Bad command: length==0 or length>MAX_LEN goes IDLE->FINISH with error=1 and no rd_en/wr_en activity.
- Tile count: ntiles = ceil(length/TILE_ELEMS). Tile index t runs 0..ntiles-1, with rd_tile_idx = wr_tile_idx = t.
- States:
  - IDLE.
  - RD_A: rd_en=1, rd_buf=A.
  - CAP_A: latch rd_data into a_reg. In modes 1/3, also issue rd_en with rd_buf=B in the same cycle.
  - CAP_B (modes 1/3 only): latch b_reg.
  - WRITE: wr_en=1; wr_data and wr_mask are registered and held stable until wr_ready. On handshake, if t==ntiles-1 go to FINISH, else t++ and go to RD_A.
  - FINISH: done=1, then IDLE.
- Latency with wr_ready=1: 3 cycles per tile (4 in ADD modes), plus 1 for FINISH.
- Mask: lane i is valid iff t*TILE_ELEMS+i < length. Invalid lanes force wr_data lane = 0.
- Arithmetic (signed; sat() clamps to [-2^(DW-1), 2^(DW-1)-1]):
  - RELU: y = a<0 ? 0 : a.
  - ADD_SAT: y = sat(a+b), computed at DW+1 bits.
  - REQUANT: p = a*scale (2*DW bits) + rnd, where rnd = shift>0 ? 2^(shift-1) : 0. Compute at 2*DW+1 bits; y = sat(p >>> shift) (arithmetic shift, round-half-up).
  - ADD_RELU: y = max(sat(a+b), 0).
- Other state rules:
  - rd_en is deasserted outside RD_A and CAP_A; all lanes are computed in parallel in WRITE.
  - busy=1 in every state except IDLE; error holds until the next accepted start.

Test Plan:
- RELU, length=40, A lanes alternating -5/7:
  - 2 tiles; lanes show 0/7.
  - Tile 1 wr_mask=0x000000FF with lanes 8..31 zero.
  - done pulses on the 7th cycle after the start cycle; no further rd_en.
- ADD_SAT, length=32, (100,100), (-100,-50), (3,-4) -> 127, -128, -1.
  - rd_buf sequence A,B.
  - done on the 5th cycle after start.
- REQUANT, scale=3, shift=2: a=5 -> 4, a=-5 -> -4.
  - scale=127, shift=0, a=127 -> 127.
  - scale=-128, a=127 -> -128.
- Backpressure, RELU length=64: hold wr_ready=0 for 5 cycles during tile 0.
  - wr_en, wr_data, wr_mask and wr_tile_idx stay stable.
  - done is delayed exactly 5 cycles versus the unstalled run.
- Bad commands (MAX_LEN=784):
  - length=0 and length=785 -> no rd_en; done 2 cycles after start with error=1.
  - The next valid start clears error.
  - A start during busy is ignored: latched fields unchanged, no extra done.
- Reset mid-operation: assert reset_n=0 in WRITE of tile 1.
  - wr_en/busy drop asynchronously and the unit is in IDLE after release.
  - A new RELU command completes correctly.
